random_word_source: RTL
=======================

Name: random_word_source

Overview:
- Produces the 16-bit random words that the game's value-randomizing logic consumes on its random-number input.
- 16-bit maximal-length Fibonacci LFSR behind a request/valid/acknowledge handshake.
- Each request advances the LFSR a fixed number of steps, then presents one word that is held stable until acknowledged.
- Seed loadable at runtime; all-zero lock-up state is prevented in hardware.

Parameters:
- SEED, 16'hACE1, LFSR value after reset; also substituted whenever a zero seed is loaded. Must be nonzero.
- STEPS_PER_WORD, 16, LFSR shifts per delivered word. Legal range 1..255; 8-bit step counter.

Ports:
- CLK  input  1  system clock, all state on rising edge
- RST  input  1  synchronous, active-high reset
- seedLoad  input  1  load seedValue into LFSR this edge; highest priority after RST
- seedValue  input  16  seed; 16'h0000 replaced by SEED
- req  input  1  request a new word; sampled only in IDLE
- ack  input  1  consumer has taken randomNumber; sampled only in HOLD
- randomNumber  output  16  delivered word, registered, stable outside word updates
- randomValid  output  1  high while randomNumber is a fresh, unacknowledged word
- busy  output  1  high while generating (GEN state)

Behaviour:
- Reset values: lfsr=SEED, randomNumber=16'h0000, randomValid=0, busy=0, state=IDLE, count=0.
- LFSR step: next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}, polynomial x^16+x^14+x^13+x^11+1, period 65535.
- Priority per edge: RST > seedLoad > FSM.
- seedLoad, any state:
  - lfsr <= (seedValue==0) ? SEED : seedValue.
  - state <= IDLE, randomValid <= 0, busy <= 0.
  - randomNumber keeps its old value.
  - An in-flight GEN is aborted and delivers no word.
  - A req in the same cycle is dropped.
- IDLE:
  - req=1: state <= GEN, count <= STEPS_PER_WORD-1, busy <= 1.
  - ack ignored.
- GEN, each edge:
  - lfsr <= next.
  - If count==0: randomNumber <= next, randomValid <= 1, busy <= 0, state <= HOLD.
  - Else: count <= count-1.
  - req and ack ignored.
- HOLD:
  - randomValid=1, randomNumber stable.
  - ack=1: randomValid <= 0, state <= IDLE.
  - req ignored, including when asserted together with ack; the consumer must re-request from IDLE.
- Latency: req sampled at edge k gives randomValid high after edge k+STEPS_PER_WORD. Next earliest req is at the edge after the ack edge.
- LFSR holds its value in IDLE and HOLD unless the optional feature is enabled.
- Zero state unreachable: nonzero reset value, zero-seed substitution, maximal-length polynomial.

Optional Feature:
- Macro: RANDOM_WORD_FREE_RUN_EN.
- Defined:
  - LFSR also advances one step every cycle in IDLE and HOLD, so the delivered word depends on the timing of player input.
  - randomNumber still updates only at GEN completion.
  - seedLoad still overrides.
- Undefined: LFSR advances only in GEN; the output sequence is fully deterministic per seed.
- All directed tests below run with the macro undefined.

Test Plan (STEPS_PER_WORD=2, SEED=16'hACE1 unless noted):
- Reset: hold RST 2 cycles -> randomNumber=0000, randomValid=0, busy=0; req one cycle -> busy high 2 cycles, then randomValid=1, randomNumber=B387; hold ack low 5 cycles -> value and valid stable.
- Back-to-back words: ack B387, then req -> randomNumber=CE1E; ack -> randomValid=0 the next cycle.
- Seed load: seedLoad with seedValue=0001, then req -> randomNumber=0004. seedLoad with seedValue=0000, then req -> randomNumber=B387 (zero replaced by SEED).
- Abort: req, then seedLoad (seedValue=ACE1) in the first GEN cycle -> busy=0, randomValid never asserts, randomNumber unchanged; a new req -> B387.
- Ignored inputs:
  - req in GEN -> no extra word.
  - req+ack together in HOLD -> IDLE with randomValid=0, no new GEN.
  - ack in IDLE -> no effect.
- RST mid-GEN, and separately mid-HOLD -> all outputs at reset values the next cycle; the following req yields B387.

Source files
------------

// File: rtl/random_word_source.sv
// random_word_source
//   Delivers 16-bit pseudo-random words from a maximal-length Fibonacci LFSR
//   (x^16 + x^14 + x^13 + x^11 + 1, period 65535) behind a req/valid/ack
//   handshake. Each request advances the LFSR STEPS_PER_WORD times, then the
//   resulting value is presented on randomNumber and held until acknowledged.
//
// Optional feature macro: RANDOM_WORD_FREE_RUN_EN
//   When defined, the LFSR also steps once per cycle in IDLE and HOLD, so the
//   delivered word depends on request timing. randomNumber still only updates
//   when a generation completes. Undefined (default): LFSR steps only in GEN.
//
// Ports:
//   CLK          in   system clock, all state on rising edge
//   RST          in   synchronous active-high reset
//   seedLoad     in   load seedValue into the LFSR (zero replaced by SEED)
//   seedValue    in   16-bit seed
//   req          in   request a new word (sampled in IDLE only)
//   ack          in   word consumed (sampled in HOLD only)
//   randomNumber out  delivered word, registered
//   randomValid  out  high while randomNumber is fresh and unacknowledged
//   busy         out  high while generating

module random_word_source #(
    parameter logic [15:0] SEED           = 16'hACE1,
    parameter int unsigned STEPS_PER_WORD = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        seedLoad,
    input  logic [15:0] seedValue,
    input  logic        req,
    input  logic        ack,
    output logic [15:0] randomNumber,
    output logic        randomValid,
    output logic        busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GEN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    // Count runs STEPS_PER_WORD-1 down to 0, so GEN lasts exactly STEPS_PER_WORD cycles.
    localparam logic [7:0] COUNT_INIT = 8'(STEPS_PER_WORD - 1);

    logic [1:0]  stateQ, stateD;
    logic [15:0] lfsrQ, lfsrD;
    logic [7:0]  countQ, countD;
    logic [15:0] numberQ, numberD;
    logic        validQ, validD;
    logic        busyQ, busyD;
    logic [15:0] lfsrNext;

    assign lfsrNext = {lfsrQ[14:0], lfsrQ[15] ^ lfsrQ[13] ^ lfsrQ[12] ^ lfsrQ[10]};

    always_comb begin
        stateD  = stateQ;
        lfsrD   = lfsrQ;
        countD  = countQ;
        numberD = numberQ;
        validD  = validQ;
        busyD   = busyQ;

        if (seedLoad) begin
            // A zero seed would lock the LFSR, so fall back to the reset seed.
            lfsrD  = (seedValue == 16'h0000) ? SEED : seedValue;
            stateD = IDLE;
            validD = 1'b0;
            busyD  = 1'b0;
        end else begin
            case (stateQ)
                IDLE: begin
`ifdef RANDOM_WORD_FREE_RUN_EN
                    lfsrD = lfsrNext;
`endif
                    if (req) begin
                        stateD = GEN;
                        countD = COUNT_INIT;
                        busyD  = 1'b1;
                    end
                end
                GEN: begin
                    lfsrD = lfsrNext;
                    if (countQ == 8'd0) begin
                        numberD = lfsrNext;
                        validD  = 1'b1;
                        busyD   = 1'b0;
                        stateD  = HOLD;
                    end else begin
                        countD = countQ - 8'd1;
                    end
                end
                HOLD: begin
`ifdef RANDOM_WORD_FREE_RUN_EN
                    lfsrD = lfsrNext;
`endif
                    // req is deliberately ignored here, even alongside ack.
                    if (ack) begin
                        validD = 1'b0;
                        stateD = IDLE;
                    end
                end
                default: begin
                    stateD = IDLE;
                    validD = 1'b0;
                    busyD  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stateQ  <= IDLE;
            lfsrQ   <= SEED;
            countQ  <= 8'd0;
            numberQ <= 16'h0000;
            validQ  <= 1'b0;
            busyQ   <= 1'b0;
        end else begin
            stateQ  <= stateD;
            lfsrQ   <= lfsrD;
            countQ  <= countD;
            numberQ <= numberD;
            validQ  <= validD;
            busyQ   <= busyD;
        end
    end

    assign randomNumber = numberQ;
    assign randomValid  = validQ;
    assign busy         = busyQ;

endmodule
